// File: rtl/debounced_input_pio_if.sv
// rtl/debounced_input_pio_if.sv - Avalon-MM slave bus bundle for the debounced input PIO
interface debounced_input_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/debounced_input_pio.sv
// rtl/debounced_input_pio.sv - synchronised, debounced, edge-capturing input PIO with maskable irq (optional PIO_TIMESTAMP_EN)
module debounced_input_pio #(
  parameter int          WIDTH           = 18,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [31:0] INPUT_INVERT    = 32'h0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  debounced_input_pio_if.slave avs,
  input  logic [WIDTH-1:0]     pio_in,
  output logic                 irq
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] mask_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] w1c;
  logic             wr_edge;
  logic             wr_mask;
  logic             wr_mode;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

`ifdef PIO_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] last_time;
`endif

  // Inversion happens before the first flop so active-low keys look active-high everywhere.
  assign raw          = pio_in ^ INPUT_INVERT[WIDTH-1:0];
  assign sync         = sync_q[SYNC_STAGES-1];
  assign wdata_w      = avs.avs_writedata[WIDTH-1:0];
  assign unused_wdata = ^avs.avs_writedata;

  assign wr_edge = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr_mask = avs.avs_write && (avs.avs_address == 2'd2);
  assign wr_mode = avs.avs_write && (avs.avs_address == 2'd3);
  assign w1c     = wr_edge ? wdata_w : '0;

  // Metastability chain for the asynchronous board inputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-channel stability counter; a new level is taken only after DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) db_nxt[i] = sync[i];
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      db <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      db <= db_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Edge qualification by MODE; flagged in the same cycle the debounced level changes.
  always_comb begin
    diff     = db ^ db_nxt;
    edge_set = '0;
    case (mode_q)
      2'd0:    edge_set = diff & db_nxt;
      2'd1:    edge_set = diff & db;
      default: edge_set = diff;
    endcase
  end

  // Control registers; a new edge overrides a simultaneous write-1-to-clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      irq    <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~w1c) | edge_set;
      if (wr_mask) mask_q <= wdata_w;
      if (wr_mode) mode_q <= avs.avs_writedata[1:0];
      irq    <= |(edge_q & mask_q);
    end
  end

`ifdef PIO_TIMESTAMP_EN
  // Free-running cycle counter; any captured edge snapshots it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ts_cnt    <= '0;
      last_time <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (|edge_set) last_time <= ts_cnt;
    end
  end
`endif

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      2'd0: rd_mux[WIDTH-1:0] = db;
      2'd1: rd_mux[WIDTH-1:0] = edge_q;
      2'd2: rd_mux[WIDTH-1:0] = mask_q;
      default: begin
        rd_mux[1:0] = mode_q;
`ifdef PIO_TIMESTAMP_EN
        rd_mux[31:2] = last_time[31:2];
`endif
      end
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs.avs_readdata <= '0;
    else if (avs.avs_read) avs.avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_debounced_input_pio.sv
// tb/tb_debounced_input_pio.sv - self-checking bench for debounced_input_pio
module tb_debounced_input_pio;

  localparam int WIDTH = 18;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n;
  logic [WIDTH-1:0] pio_in;
  logic [WIDTH-1:0] pio_inv;
  logic             irq0;
  logic             irq1;

  int n_checks = 0;
  int n_fail   = 0;

  debounced_input_pio_if avs0();
  debounced_input_pio_if avs1();

  debounced_input_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .INPUT_INVERT(32'h0)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs(avs0.slave), .pio_in(pio_in), .irq(irq0)
  );

  debounced_input_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .INPUT_INVERT(32'hF)) dut_inv (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs(avs1.slave), .pio_in(pio_inv), .irq(irq1)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [12];

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs0.avs_address   = a;
    avs0.avs_writedata = d;
    avs0.avs_write     = 1'b1;
    tick();
    avs0.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs0.avs_address = a;
    avs0.avs_read    = 1'b1;
    tick();
    d = avs0.avs_readdata;
    avs0.avs_read    = 1'b0;
  endtask

  task automatic bus_write1(input logic [1:0] a, input logic [31:0] d);
    avs1.avs_address   = a;
    avs1.avs_writedata = d;
    avs1.avs_write     = 1'b1;
    tick();
    avs1.avs_write     = 1'b0;
  endtask

  task automatic bus_read1(input logic [1:0] a, output logic [31:0] d);
    avs1.avs_address = a;
    avs1.avs_read    = 1'b1;
    tick();
    d = avs1.avs_readdata;
    avs1.avs_read    = 1'b0;
  endtask

  // Streams DATA reads every cycle; returns the cycle count until bit b reads 1 (20 if never).
  task automatic measure_data(input int b, output int n, output logic [31:0] last);
    n = 20;
    avs0.avs_address = 2'd0;
    avs0.avs_read    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (avs0.avs_readdata[b]) begin
        n = k;
        break;
      end
    end
    last = avs0.avs_readdata;
    avs0.avs_read = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    logic        irq_seen;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,        32'h0003_FFFF};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0003};
    vecs[8]  = '{1'b1, 2'd0, 32'h0000_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 2'd3, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 2'd2, 32'h0,        32'h0};

    reset_reset_n      = 1'b0;
    pio_in             = '0;
    pio_inv            = 18'hF;
    avs0.avs_address   = '0; avs0.avs_read = 1'b0; avs0.avs_write = 1'b0; avs0.avs_writedata = '0;
    avs1.avs_address   = '0; avs1.avs_read = 1'b0; avs1.avs_write = 1'b0; avs1.avs_writedata = '0;
    tick(); tick(); tick();
    reset_reset_n = 1'b1;

    check("reset_readdata", avs0.avs_readdata, 32'h0);
    check("reset_irq", {31'b0, irq0}, 32'h0);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].wr) bus_write(vecs[v].addr, vecs[v].data);
      else begin
        bus_read(vecs[v].addr, rd);
        check($sformatf("reg_vec%0d", v), rd, vecs[v].exp);
      end
    end

    // Clean rising step on channel 0 in MODE 0: db after 6 cycles, visible on the 7th read.
    pio_in[0] = 1'b1;
    measure_data(0, n, rd);
    check("step_latency", 32'(n), 32'd7);
    check("step_data", rd, 32'h1);
    bus_read(2'd1, rd);
    check("step_edge", rd, 32'h1);
    check("step_irq_unmasked", {31'b0, irq0}, 32'h0);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    check("edge_w1c", rd, 32'h0);

    // 3-cycle glitch on channel 5 must be rejected.
    bus_write(2'd2, 32'h3FFFF);
    pio_in[5] = 1'b1;
    tick(); tick(); tick();
    pio_in[5] = 1'b0;
    irq_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      irq_seen = irq_seen | irq0;
    end
    bus_read(2'd0, rd);
    check("glitch_data", rd, 32'h1);
    bus_read(2'd1, rd);
    check("glitch_edge", rd, 32'h0);
    check("glitch_irq", {31'b0, irq_seen}, 32'h0);

    // Falling edge in MODE 1 with MASK=1: EDGE at cycle 6, irq at cycle 7, clear drops irq a cycle later.
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'h1);
    pio_in[0] = 1'b0;
    n = 20;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (irq0) begin
        n = k;
        break;
      end
    end
    check("fall_irq_latency", 32'(n), 32'd7);
    bus_read(2'd1, rd);
    check("fall_edge", rd, 32'h1);
    bus_write(2'd1, 32'h1);
    check("fall_irq_hold", {31'b0, irq0}, 32'h1);
    tick();
    check("fall_irq_clear", {31'b0, irq0}, 32'h0);

    // W1C on EDGE[2] lands in the very cycle channel 2's rising edge is accepted: set wins.
    bus_write(2'd3, 32'h0);
    pio_in[2] = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd);
    check("set_wins_edge", rd, 32'h4);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd);
    check("set_wins_cleared", rd, 32'h0);

    // Reset in the middle of channel 7's debounce; channels 2 and 7 re-qualify from scratch.
    pio_in[7] = 1'b1;
    bus_read(2'd0, rd);
    check("pre_reset_data", rd, 32'h4);
    tick(); tick(); tick();
    reset_reset_n = 1'b0;
    #1;
    check("reset_clears_readdata", avs0.avs_readdata, 32'h0);
    tick(); tick();
    reset_reset_n = 1'b1;
    measure_data(7, n, rd);
    check("post_reset_latency", 32'(n), 32'd7);
    check("post_reset_data", rd, 32'h84);
    check("post_reset_irq", {31'b0, irq0}, 32'h0);
    bus_read(2'd2, rd);
    check("post_reset_mask", rd, 32'h0);
    bus_read(2'd1, rd);
    check("post_reset_edge", rd, 32'h84);

    // Inverted instance: inputs held high since reset look idle.
    bus_write1(2'd2, 32'hF);
    bus_read1(2'd0, rd);
    check("inv_data", rd, 32'h0);
    bus_read1(2'd1, rd);
    check("inv_edge", rd, 32'h0);
    tick();
    check("inv_irq", {31'b0, irq1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/debounced_input_pio.md
Name: debounced_input_pio

Overview:
- Parametrised successor to the plain keys/switches input PIOs in the Qsys system: one generic Avalon-MM slave for up to 32 input channels.
- Adds per-channel input synchronisation, debouncing, selectable edge capture and a maskable interrupt.
- Replaces the separate fixed-width keys (4-bit) and switches (18-bit) input PIOs; instantiated once per input group.

Parameters:
WIDTH, 18, number of input channels (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (1 ms at 50 MHz); minimum 1
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
INPUT_INVERT, 0, WIDTH-bit mask; set bits invert the raw input before synchronisation (active-low keys)

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous active-low reset
avs_address  input  2  word address
avs_read  input  1  read strobe
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_readdata  output  32  read data, registered
pio_in  input  WIDTH  raw asynchronous inputs from the board
irq  output  1  level interrupt to the Nios II

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, debounced state, counters, EDGE, MASK, MODE, avs_readdata and irq go to 0.
- Input path: raw = pio_in ^ INPUT_INVERT, passed through a SYNC_STAGES flop chain. Output of the chain is sync[i].
- Debounce, per channel:
  - Counter cnt[i] has width clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == db[i], cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments each cycle.
  - When cnt[i] reaches DEBOUNCE_CYCLES-1 and sync[i] still differs, db[i] takes sync[i] and cnt[i] clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes db. The counter never wraps.
- Latency: a clean step on pio_in appears on db after SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge detect, on db transitions:
  - MODE 0: rising edges only.
  - MODE 1: falling edges only.
  - MODE 2 or 3: both edges.
  - A detected edge sets EDGE[i] in the cycle db[i] changes.
- Register map (word addresses):
  - 0 DATA: RO, db zero-extended to 32 bits. Writes ignored.
  - 1 EDGE: read returns EDGE. Write-1-to-clear per bit.
  - 2 MASK: RW, WIDTH bits.
  - 3 MODE: RW, bits[1:0]. Other bits read 0.
- Read latency is 1: avs_readdata is updated the cycle after avs_read and holds until the next read.
- Simultaneous events: an edge detected in the same cycle as a W1C write to that bit leaves the bit set (set wins).
- A MODE write takes effect from the next cycle and does not clear EDGE.
- irq is a registered |(EDGE & MASK), so it asserts 1 cycle after the enabling condition. It stays high until every masked bit is cleared or masked off.
- A write and a read in the same cycle: the write is applied, and the read returns the pre-write value.
- Reset asserted mid-debounce discards all pending counts. After release, db starts at 0, and an input held at 1 is accepted after the full debounce time and produces a rising edge.

Optional Feature:
- Macro: PIO_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is included.
  - Each edge capture latches the counter value into a LAST_EDGE_TIME register.
  - This register is readable at address 3, bits[31:2], i.e. count >> 2; MODE remains in bits[1:0].
  - The latched value is updated on any edge in any channel. If several channels edge in the same cycle, one value is stored.
- When undefined: no counter is built, and bits[31:2] of address 3 read 0.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2: step pio_in[0] 0->1 and hold -> DATA[0]=1 exactly 6 cycles after the step; EDGE reads 0x1 in MODE 0.
- 3-cycle pulse on pio_in[5] -> DATA and EDGE remain 0; irq stays 0.
- MASK=0x1, MODE=1: hold pio_in[0] high then release -> EDGE[0]=1 after the falling edge is accepted; irq=1 one cycle later; write EDGE=0x1 -> irq=0 next cycle.
- INPUT_INVERT=0xF, pio_in[3:0] held at 0xF from reset -> DATA reads 0x0 and no edge ever captured.
- W1C write to EDGE[2] in the same cycle a new rising edge on channel 2 is accepted -> EDGE[2] reads 1 afterwards.
- Assert reset_reset_n low mid-debounce (cnt=2) -> after release, DATA=0 and debounce restarts from 0 (full 6-cycle latency).
